// File: rtl/ppi_scan_pkg.sv
// Shared types for the PPI scan harness: command opcodes, FSM states and
// the default MISR feedback polynomial.
package ppi_scan_pkg;

  typedef enum logic [1:0] {
    OP_RUN     = 2'b00,
    OP_CAPTURE = 2'b01,
    OP_SHIFT   = 2'b10,
    OP_CLEAR   = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SHIFT,
    S_CAPT,
    S_CLR
  } fsm_state_e;

  localparam logic [15:0] DEF_POLY = 16'h8016;

endpackage

// File: rtl/ppi_scan_harness_if.sv
// Command handshake between the controlling bench and the scan harness.
// master drives the request, slave (the harness) answers with cmd_ready.
interface ppi_scan_harness_if #(
  parameter int unsigned CNT_W = 16
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  ppi_scan_pkg::cmd_op_e cmd_op;
  logic [CNT_W-1:0]      cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/ppi_scan_misr.sv
// Multiple-input signature register compacting the partial outputs of the
// cone. Wide inputs are zero-extended and XOR-folded down to SIG_W bits.
module ppi_scan_misr #(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(ppi_scan_pkg::DEF_POLY),
  parameter int unsigned      N_PO  = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [N_PO-1:0]  data,
  output logic [SIG_W-1:0] sig
);

  localparam int unsigned NCH = (N_PO + SIG_W - 1) / SIG_W;

  logic [NCH*SIG_W-1:0] data_ext;
  logic [SIG_W-1:0]     fold;
  logic [SIG_W-1:0]     sig_q;
  logic [SIG_W-1:0]     sig_d;

  // fold the zero-extended input into one SIG_W word and form the next signature
  always_comb begin
    data_ext           = '0;
    data_ext[N_PO-1:0] = data;
    fold               = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      fold = fold ^ data_ext[i*SIG_W +: SIG_W];
    end
    sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
  end

  // signature register: cleared by reset or CLEAR, advanced on enable
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig_q <= '0;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/ppi_scan_harness.sv
// PPI scan harness: state register feeding an external combinational cone,
// partial-output capture register, and a shared scan chain {ppi_q, po_q}.
// Build option: define PPI_SCAN_MISR_EN to add the po_d signature (sig_q).
module ppi_scan_harness
  import ppi_scan_pkg::*;
#(
  parameter int unsigned      N_PPI = 5,
  parameter int unsigned      N_PO  = 19,
  parameter int unsigned      CNT_W = 16,
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
  input  logic              CK,
  input  logic              RST,
  ppi_scan_harness_if.slave cmd,
  input  logic [N_PPI-1:0]  ns_d,
  input  logic [N_PO-1:0]   po_d,
  output logic [N_PPI-1:0]  ppi_q,
  output logic [N_PO-1:0]   po_q,
  input  logic              scan_in,
  output logic              scan_out,
  output logic              busy,
  output logic              done
`ifdef PPI_SCAN_MISR_EN
  ,
  output logic [SIG_W-1:0]  sig_q
`endif
);

  localparam int unsigned L = N_PPI + N_PO;

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             ready_w;
  logic             run_en, capt_en, shift_en, clr_en;
  logic [L-1:0]     chain_cur;
  logic [L-1:0]     chain_shl;

  // FSM state, cycle counter and registered completion pulse
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // next state: zero-length RUN/SHIFT complete straight from IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            OP_RUN, OP_SHIFT: begin
              if (cmd.cmd_len == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = (cmd.cmd_op == OP_RUN) ? S_RUN : S_SHIFT;
                cnt_d   = cmd.cmd_len;
              end
            end
            OP_CAPTURE: state_d = S_CAPT;
            OP_CLEAR:   state_d = S_CLR;
            default:    state_d = S_IDLE;
          endcase
        end
      end
      S_RUN, S_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_CAPT, S_CLR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // per-state datapath enables and handshake outputs
  always_comb begin
    ready_w  = (state_q == S_IDLE);
    run_en   = (state_q == S_RUN);
    shift_en = (state_q == S_SHIFT);
    capt_en  = (state_q == S_CAPT);
    clr_en   = (state_q == S_CLR);
  end

  assign cmd.cmd_ready = ready_w;
  assign busy          = ~ready_w;
  assign done          = done_q;

  assign chain_cur = {ppi_q, po_q};
  assign chain_shl = {chain_cur[L-2:0], scan_in};
  assign scan_out  = chain_cur[L-1];

  // state / partial-output registers: clear, cone update, capture or scan shift
  always_ff @(posedge CK) begin
    if (RST || clr_en) begin
      ppi_q <= '0;
      po_q  <= '0;
    end else if (run_en) begin
      ppi_q <= ns_d;
      po_q  <= po_d;
    end else if (capt_en) begin
      po_q  <= po_d;
    end else if (shift_en) begin
      {ppi_q, po_q} <= chain_shl;
    end
  end

`ifdef PPI_SCAN_MISR_EN
  ppi_scan_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .N_PO  (N_PO)
  ) u_misr (
    .clk  (CK),
    .rst  (RST),
    .en   (run_en | capt_en),
    .clr  (clr_en),
    .data (po_d),
    .sig  (sig_q)
  );
`else
  logic unused_misr_cfg;
  assign unused_misr_cfg = (^POLY) ^ (SIG_W == 0);
`endif

endmodule

// File: doc/ppi_scan_harness.md
Name: ppi_scan_harness

Overview:
- Re-inserts the state flip-flops stripped from a combinationally converted benchmark cone, e.g. s820 with 5 FFs, 18 PIs and 19 POs.
- Holds the pseudo-primary-input (PPI) state register that feeds an external cone, and captures its next-state and partial outputs.
- Exposes both registers as one scan chain.
- Sequenced by a command handshake so the fault-injection/test bench can run, capture, shift and clear under control.

Parameters:
N_PPI, 5, width of state register / next-state bus
N_PO, 19, width of captured partial-output register
CNT_W, 16, width of cmd_len and internal cycle counter
SIG_W, 16, signature width (MISR_EN only)
POLY, 16'h8016, MISR feedback polynomial (MISR_EN only)

Ports:
CK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  00 RUN, 01 CAPTURE, 10 SHIFT, 11 CLEAR
cmd_len  in  CNT_W  cycle count for RUN/SHIFT
ns_d  in  N_PPI  next-state from cone
po_d  in  N_PO  partial outputs from cone
ppi_q  out  N_PPI  state register, drives cone PPIs
po_q  out  N_PO  captured partial outputs
scan_in  in  1  serial chain input
scan_out  out  1  serial chain output
busy  out  1  FSM not IDLE
done  out  1  one-cycle completion pulse
sig_q  out  SIG_W  signature (present only with MISR_EN)

Behaviour:
- Clock and reset: one clock, CK. Reset is synchronous and active-high on RST.
- Reset values: ppi_q=0, po_q=0, done=0, busy=0, FSM=IDLE, counter=0, sig_q=0.
- RST mid-command aborts it: IDLE next cycle, no done pulse.
- FSM states: IDLE, RUN, SHIFT, CAPT, CLR.
- Accept: cmd_valid&&cmd_ready at edge t latches op and len; the FSM leaves IDLE at t+1.
- While busy, cmd_valid is ignored and no command is queued.
- RUN, len N>0:
  - Edges t+1..t+N each load ppi_q<=ns_d and po_q<=po_d.
  - The counter decrements from N; at count 1 the FSM returns to IDLE.
  - done=1 and cmd_ready=1 in cycle t+N+1; back-to-back accept in that cycle is legal.
- SHIFT, len N>0:
  - Chain C={ppi_q,po_q}, length L=N_PPI+N_PO, MSB=ppi_q[N_PPI-1].
  - Each of N edges: C<={C[L-2:0],scan_in}.
  - scan_out=C[L-1], registered source, valid every cycle including IDLE.
- len=0 for RUN/SHIFT: no register update; IDLE with done=1 at t+1.
- CAPTURE: single edge t+1, po_q<=po_d, ppi_q held. done at t+2.
- CLEAR: single edge t+1, ppi_q=0, po_q=0 (sig_q=0 if MISR_EN). done at t+2.
- busy = FSM!=IDLE. done is registered and never high with busy.
- Counter: CNT_W bits, loaded with len. Max len 2^CNT_W-1; no wrap.

Optional Feature:
- Macro PPI_SCAN_MISR_EN.
- Defined: sig_q port exists. Every edge that loads po_q (RUN, CAPTURE) also updates the signature:
  - sig <= (sig<<1) ^ (sig[SIG_W-1]?POLY:0) ^ fold(po_d).
  - fold = XOR of po_d zero-extended to a multiple of SIG_W, split into SIG_W chunks.
- SHIFT does not touch sig.
- Undefined: no sig_q port, no MISR logic; all other behaviour identical.

Decomposition:
- Package ppi_scan_pkg: cmd_op_e (RUN/CAPTURE/SHIFT/CLEAR encodings), fsm_state_e, default POLY constant.
- One sub-module ppi_scan_misr (SIG_W, POLY, N_PO; en, clr, data in; sig out), instantiated only under the macro.

Test Plan:
- Reset: RST high 2 cycles mid-RUN (len=10) -> ppi_q=0, po_q=0, busy=0, cmd_ready=1, no done pulse.
- RUN len=3, cone model ns=ppi_q+1 (mod 32), start 0 -> ppi_q=3 after 3 updates; done high exactly in cycle t+4.
- CAPTURE with po_d=19'h5A5A5, ppi_q=5'h0B -> po_q=19'h5A5A5, ppi_q unchanged 5'h0B, done at t+2.
- SHIFT len=24 with scan_in pattern 24'hC3A5F1 (MSB first) -> ppi_q=5'h18, po_q=19'h3A5F1; scan_out emits prior chain MSB first.
- SHIFT/RUN len=0 -> no change, done at t+1. cmd_valid held during busy -> exactly one command executed.
- PPI_SCAN_MISR_EN: CLEAR then CAPTURE po_d=19'h00001 twice -> sig_q=16'h0001 then 16'h0003; SHIFT leaves sig_q 16'h0003.
